mem_hex_dumper: RTL

Hardware memory dump engine. Reads a programmed address range from the synchronous system memory and streams it as ASCII hex text, one character per valid/ready handshake. It is the encoding counterpart of the bench's hex firmware loader: the loader turns hex text into memory bytes, and this block turns memory bytes back into hex text, for a debug UART or a bench text sink. It sits beside the CPU on the memory read port. The bus arbiter grants that port only while `busy` is high.

---
 rtl/mem_hex_dumper.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_hex_dumper.sv
// Memory dump engine: reads an inclusive address range over the synchronous read
// port and streams it as ASCII hex lines ("AAAA: hh hh ..\n") through valid/ready.
module mem_hex_dumper #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_LINE = 16,
  parameter int UPPERCASE      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  char_valid,
  output logic [7:0]            char_data,
  input  logic                  char_ready
);

  localparam int NIB = ADDR_WIDTH / 4;

  typedef enum logic [3:0] {
    S_IDLE, S_PFX, S_COLON, S_SP, S_RD, S_WT, S_HI, S_LO, S_SEP, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   remain_q, remain_d;  // bytes left after the current one
  logic [7:0]              line_q, line_d;
  logic [7:0]              nib_q, nib_d;
  logic [DATA_WIDTH-1:0]   byte_q, byte_d;
  logic                    busy_q, busy_d, done_q, done_d;
  logic                    rd_en_q, rd_en_d, cv_q, cv_d;
  logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic [7:0]              cd_q, cd_d;
  logic                    hs;
  int                      sh;
  logic [ADDR_WIDTH-1:0]   pfx_shift;

  function automatic logic [7:0] hex(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return ((UPPERCASE != 0) ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  assign hs = cv_q & char_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    line_d   = line_q;
    nib_d    = nib_q;
    byte_d   = byte_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_PFX;
        addr_d   = start_addr;
        remain_d = end_addr - start_addr;
        line_d   = 8'd0;
        nib_d    = 8'd0;
      end
      S_PFX: if (hs) begin
        if (nib_q == 8'(NIB - 1)) state_d = S_COLON;
        else nib_d = nib_q + 8'd1;
      end
      S_COLON: if (hs) state_d = S_SP;
      S_SP:    if (hs) state_d = S_RD;
      S_RD:    state_d = S_WT;
      S_WT: begin
        byte_d  = mem_rdata;
        state_d = S_HI;
      end
      S_HI: if (hs) state_d = S_LO;
      S_LO: if (hs) state_d = S_SEP;
      S_SEP: if (hs) begin
        if (remain_q == '0) state_d = S_DONE;
        else begin
          addr_d   = addr_q + 1'b1;
          remain_d = remain_q - 1'b1;
          if (line_q == 8'(BYTES_PER_LINE - 1)) begin
            line_d  = 8'd0;
            nib_d   = 8'd0;
            state_d = S_PFX;
          end else begin
            line_d  = line_q + 8'd1;
            state_d = S_RD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are derived from the next state so they register alongside it.
    sh        = 4 * (NIB - 1 - int'(nib_d));
    pfx_shift = addr_d >> sh;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    rd_en_d   = (state_d == S_RD);
    maddr_d   = (state_d == S_RD) ? addr_d : '0;
    cv_d      = 1'b0;
    cd_d      = cd_q;
    case (state_d)
      S_PFX:   begin cv_d = 1'b1; cd_d = hex(pfx_shift[3:0]); end
      S_COLON: begin cv_d = 1'b1; cd_d = 8'h3A; end
      S_SP:    begin cv_d = 1'b1; cd_d = 8'h20; end
      S_HI:    begin cv_d = 1'b1; cd_d = hex(byte_d[7:4]); end
      S_LO:    begin cv_d = 1'b1; cd_d = hex(byte_d[3:0]); end
      S_SEP: begin
        cv_d = 1'b1;
        cd_d = ((line_d == 8'(BYTES_PER_LINE - 1)) || (remain_d == '0)) ? 8'h0A : 8'h20;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      line_q   <= '0;
      nib_q    <= '0;
      byte_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      maddr_q  <= '0;
      cv_q     <= 1'b0;
      cd_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      line_q   <= line_d;
      nib_q    <= nib_d;
      byte_q   <= byte_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      maddr_q  <= maddr_d;
      cv_q     <= cv_d;
      cd_q     <= cd_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = maddr_q;
  assign char_valid = cv_q;
  assign char_data  = cd_q;

endmodule
